// File: rtl/async_fifo_1clk.sv
// async_fifo_1clk: single-clock FIFO with a first-word-fall-through read port.
// It keeps the dual-port interface and flag set of a clock-crossing FIFO, but both
// ports run on wb_clk_i.
//
// Parameters:
//   W        data width in bits
//   DP       depth in words (power of 2, >= 2)
//   WR_FAST  1: full from pointers only; 0: full also held one extra cycle
//   RD_FAST  1: empty from pointers only; 0: empty also held one extra cycle
//
// Ports:
//   wb_clk_i  clock, all state changes on its rising edge
//   wb_rst_i  synchronous active-high reset (pointers and slow flags only)
//   wr_en     push wr_data this cycle (ignored while full)
//   wr_data   word to push
//   full      no write accepted
//   afull     count >= DP-1
//   rd_en     pop the head word this cycle (ignored while empty)
//   rd_data   head word, combinational (valid while empty=0)
//   empty     no word available
//   aempty    count <= 1
module async_fifo_1clk #(
    parameter int unsigned W       = 32,
    parameter int unsigned DP      = 4,
    parameter bit          WR_FAST = 1'b1,
    parameter bit          RD_FAST = 1'b1
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic         afull,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         aempty
);

    localparam int unsigned AW = $clog2(DP);
    localparam logic [AW:0] One = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem [DP];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        full_q;
    logic        empty_q;

    logic [AW:0] count;
    logic [AW:0] afull_lvl;
    logic        full_fast;
    logic        empty_fast;
    logic        wr_go;
    logic        rd_go;

    always_comb begin
        count      = wr_ptr_q - rd_ptr_q;
        afull_lvl  = DP[AW:0] - One;
        full_fast  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty_fast = (wr_ptr_q == rd_ptr_q);

        // Slow flags assert immediately but release one cycle late: never optimistic.
        full   = WR_FAST ? full_fast : (full_fast | full_q);
        empty  = RD_FAST ? empty_fast : (empty_fast | empty_q);
        afull  = (count >= afull_lvl);
        aempty = (count <= One);

        // Gate on the visible flags so a slow flag also blocks the operation.
        wr_go   = wr_en && !full;
        rd_go   = rd_en && !empty;
        rd_data = mem[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b0;
        end else begin
            full_q  <= full_fast;
            empty_q <= empty_fast;
            if (wr_go) begin
                wr_ptr_q <= wr_ptr_q + One;
            end
            if (rd_go) begin
                rd_ptr_q <= rd_ptr_q + One;
            end
        end
    end

    // Storage is not reset; a reset only discards words by clearing the pointers.
    always_ff @(posedge wb_clk_i) begin
        if (wr_go && !wb_rst_i) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_async_fifo_1clk.sv
module tb_async_fifo_1clk;

    localparam int DP = 4;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wr_data;

    logic       f_full, f_afull, f_empty, f_aempty;
    logic [7:0] f_rd_data;
    logic       s_full, s_afull, s_empty, s_aempty;
    logic [7:0] s_rd_data;

    int checks   = 0;
    int failures = 0;

    // Reference models: plain queues plus the one-cycle flag memory of the slow variant.
    logic [7:0] fq[$];
    logic [7:0] sq[$];
    bit         s_full_mem;
    bit         s_empty_mem;

    async_fifo_1clk #(.W(8), .DP(DP), .WR_FAST(1'b1), .RD_FAST(1'b1)) u_fast (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (f_full),
        .afull    (f_afull),
        .rd_en    (rd_en),
        .rd_data  (f_rd_data),
        .empty    (f_empty),
        .aempty   (f_aempty)
    );

    async_fifo_1clk #(.W(8), .DP(DP), .WR_FAST(1'b0), .RD_FAST(1'b0)) u_slow (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (s_full),
        .afull    (s_afull),
        .rd_en    (rd_en),
        .rd_data  (s_rd_data),
        .empty    (s_empty),
        .aempty   (s_aempty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit fe, ff, se, sf;
        if (rst) begin
            fq.delete();
            sq.delete();
            s_full_mem  = 1'b0;
            s_empty_mem = 1'b0;
        end else begin
            fe = (fq.size() == 0);
            ff = (fq.size() == DP);
            if (rd_en && !fe) void'(fq.pop_front());
            if (wr_en && !ff) fq.push_back(wr_data);
            se = (sq.size() == 0) || s_empty_mem;
            sf = (sq.size() == DP) || s_full_mem;
            s_empty_mem = (sq.size() == 0);
            s_full_mem  = (sq.size() == DP);
            if (rd_en && !se) void'(sq.pop_front());
            if (wr_en && !sf) sq.push_back(wr_data);
        end
    endtask

    task automatic model_check();
        bit se;
        check("f_empty", f_empty, fq.size() == 0);
        check("f_full", f_full, fq.size() == DP);
        check("f_afull", f_afull, fq.size() >= DP - 1);
        check("f_aempty", f_aempty, fq.size() <= 1);
        if (fq.size() != 0) check("f_rd_data", f_rd_data, fq[0]);
        se = (sq.size() == 0) || s_empty_mem;
        check("s_empty", s_empty, se);
        check("s_full", s_full, (sq.size() == DP) || s_full_mem);
        check("s_afull", s_afull, sq.size() >= DP - 1);
        check("s_aempty", s_aempty, sq.size() <= 1);
        if (!se) check("s_rd_data", s_rd_data, sq[0]);
    endtask

    // Inputs change just after a falling edge; outputs are compared at the next one.
    task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rd);
        rst     = r;
        wr_en   = w;
        wr_data = d;
        rd_en   = rd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_check();
    endtask

    typedef struct {
        bit         rst;
        bit         wr;
        logic [7:0] d;
        bit         rd;
        bit         e;
        bit         f;
        bit         af;
        bit         ae;
        bit         chkd;
        logic [7:0] q;
    } vec_t;

    vec_t tbl[11];

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        s_full_mem = 1'b0; s_empty_mem = 1'b0;

        // Reset, pop-while-empty, fill to full with a dropped 5th push, then drain.
        tbl[0]  = '{1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h00};
        tbl[1]  = '{0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h00};
        tbl[2]  = '{0, 1, 8'h11, 0, 0, 0, 0, 1, 1, 8'h11};
        tbl[3]  = '{0, 1, 8'h22, 0, 0, 0, 0, 0, 1, 8'h11};
        tbl[4]  = '{0, 1, 8'h33, 0, 0, 0, 1, 0, 1, 8'h11};
        tbl[5]  = '{0, 1, 8'h44, 0, 0, 1, 1, 0, 1, 8'h11};
        tbl[6]  = '{0, 1, 8'h55, 0, 0, 1, 1, 0, 1, 8'h11};
        tbl[7]  = '{0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h22};
        tbl[8]  = '{0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h33};
        tbl[9]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h44};
        tbl[10] = '{0, 0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h00};

        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].d, tbl[i].rd);
            check("tbl_empty", f_empty, tbl[i].e);
            check("tbl_full", f_full, tbl[i].f);
            check("tbl_afull", f_afull, tbl[i].af);
            check("tbl_aempty", f_aempty, tbl[i].ae);
            if (tbl[i].chkd) check("tbl_rd_data", f_rd_data, tbl[i].q);
        end

        // Wrap-around: 10 rounds of push 2 / pop 2, data 0..19.
        step(1, 0, 8'h00, 0);
        for (int r = 0; r < 10; r++) begin
            step(0, 1, 8'(2 * r), 0);
            step(0, 1, 8'(2 * r + 1), 0);
            check("wrap_head0", f_rd_data, 8'(2 * r));
            step(0, 0, 8'h00, 1);
            check("wrap_head1", f_rd_data, 8'(2 * r + 1));
            check("wrap_full", f_full, 1'b0);
            step(0, 0, 8'h00, 1);
            check("wrap_empty", f_empty, 1'b1);
        end

        // Simultaneous push+pop at count 2, then at full.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h01, 0);
        step(0, 1, 8'h02, 0);
        step(0, 1, 8'hA5, 1);
        check("pp_aempty", f_aempty, 1'b0);
        check("pp_afull", f_afull, 1'b0);
        check("pp_head", f_rd_data, 8'h02);
        step(0, 1, 8'h03, 0);
        step(0, 1, 8'h04, 0);
        check("pp_full", f_full, 1'b1);
        step(0, 1, 8'h77, 1);
        check("pp_full_drop", f_full, 1'b0);
        check("pp_full_afull", f_afull, 1'b1);
        check("pp_full_head", f_rd_data, 8'hA5);

        // Slow flags: late release of empty and of full.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h7E, 0);
        check("slow_empty_hold", s_empty, 1'b1);
        check("fast_empty_rel", f_empty, 1'b0);
        step(0, 0, 8'h00, 0);
        check("slow_empty_rel", s_empty, 1'b0);
        check("slow_head", s_rd_data, 8'h7E);
        step(0, 1, 8'h81, 0);
        step(0, 1, 8'h82, 0);
        step(0, 1, 8'h83, 0);
        check("slow_full", s_full, 1'b1);
        step(0, 0, 8'h00, 1);
        check("slow_full_hold", s_full, 1'b1);
        check("fast_full_rel", f_full, 1'b0);
        step(0, 0, 8'h00, 0);
        check("slow_full_rel", s_full, 1'b0);

        // Reset mid-stream with 3 words stored; reset beats a concurrent push and pop.
        step(1, 0, 8'h00, 0);
        step(0, 1, 8'h10, 0);
        step(0, 1, 8'h20, 0);
        step(0, 1, 8'h30, 0);
        step(1, 1, 8'h99, 1);
        check("rst_mid_empty", f_empty, 1'b1);
        check("rst_mid_s_empty", s_empty, 1'b1);
        check("rst_mid_aempty", f_aempty, 1'b1);
        step(0, 1, 8'hC3, 0);
        check("rst_mid_head", f_rd_data, 8'hC3);
        step(0, 0, 8'h00, 0);
        check("rst_mid_s_head", s_rd_data, 8'hC3);

        // Randomized traffic against the queue models.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                 8'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
